crossover_ctrl: RTL and testbench
=================================

CROSSOVER_CTRL -- requirements
Module: crossover_ctrl

Interface
REQ-001 Parameter GENE_LEN, default 12, is the number of characters per gene.
REQ-002 Parameter CHAR_WIDTH, default 8, is the bits per character.
REQ-003 Parameter TIMEOUT, default 255, is the maximum number of WAIT_MUT cycles before the block aborts.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request a crossover; sampled only in IDLE.
REQ-008 parent_a  in  GENE_LEN*CHAR_WIDTH  first parent; char i is at bits [i*CHAR_WIDTH +: CHAR_WIDTH].
REQ-009 parent_b  in  GENE_LEN*CHAR_WIDTH  second parent; same packing as parent_a.
REQ-010 child_out  out  GENE_LEN*CHAR_WIDTH  crossover child, presented to the mutation stage.
REQ-011 mut_start  out  1  one-cycle request to the mutation stage.
REQ-012 mut_done  in  1  mutation-stage completion pulse.
REQ-013 mutant_in  in  GENE_LEN*CHAR_WIDTH  mutated gene returned by the mutation stage.
REQ-014 result_out  out  GENE_LEN*CHAR_WIDTH  final gene (the mutant, or the child on timeout).
REQ-015 point_out  out  4  crossover point used by the current or last operation.
REQ-016 busy  out  1  high in every state other than IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  timeout flag; valid while done=1, then held until the next start.

Function
REQ-019 The FSM SHALL have the states IDLE, BUILD, HANDOFF, WAIT_MUT and FINISH.
REQ-020 A 16-bit LFSR (seed 16'hACE1, feedback bit15^bit13^bit12^bit10 shifted into the LSB) SHALL advance every cycle regardless of state.
REQ-021 IDLE with start=1 SHALL capture parent_a and parent_b, capture point = lfsr[3:0] (minus GENE_LEN if >= GENE_LEN), clear the gene index, clear err, and go to BUILD.
REQ-022 BUILD SHALL write one character per cycle: child[idx] = parent_a[idx] if idx < point, else parent_b[idx]; idx increments; after idx = GENE_LEN-1 the FSM goes to HANDOFF (GENE_LEN cycles).
REQ-023 Point 0 SHALL yield a child made entirely of parent_b characters; no point value yields a child made entirely of parent_a characters.
REQ-024 HANDOFF SHALL assert mut_start for exactly one cycle while child_out is stable, then go to WAIT_MUT with the watchdog cleared.
REQ-025 In WAIT_MUT, mut_done=1 SHALL capture mutant_in into result_out and go to FINISH.
REQ-026 If the watchdog reaches TIMEOUT in WAIT_MUT without mut_done, the block SHALL load child_out into result_out, set err=1 and go to FINISH.
REQ-027 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-028 Latency: with start sampled at cycle T, mut_start SHALL be high at T+GENE_LEN+1; mut_done sampled at cycle M gives done=1 at M+1.
REQ-029 start outside IDLE SHALL be ignored; parent input changes after capture SHALL NOT affect the child.
REQ-030 mut_done outside WAIT_MUT (including during the HANDOFF cycle) SHALL be ignored.
REQ-031 If mut_done arrives in the same cycle the watchdog reaches TIMEOUT, mut_done SHALL win and err=0.
REQ-032 child_out and result_out SHALL hold their values until overwritten by the next operation.

Reset
REQ-033 rst=1 at a clock edge SHALL force: state IDLE, idx 0, lfsr 16'hACE1, watchdog 0, child_out 0, result_out 0, point_out 0, mut_start 0, done 0, err 0, busy 0.
REQ-034 Reset mid-operation SHALL abort without generating a done or mut_start pulse.

Structure
REQ-035 Package ga_pkg SHALL hold GENE_LEN, CHAR_WIDTH, the LFSR seed and taps, and a gene character type; this block and the mutation stage SHALL both import it.
REQ-036 The LFSR SHALL be a sub-module ga_lfsr16 (ports clk, rst, state out) so it can be reused by other GA blocks; the FSM state type SHALL stay local to crossover_ctrl.

Verification
REQ-037 Pulse start in the first cycle after reset (lfsr=16'hACE1), with parent_a="AAAAAAAAAAAA" and parent_b="BBBBBBBBBBBB" -> point_out=1, child = 'A' in char 0 and 'B' in chars 1-11, mut_start at T+13.
REQ-038 A responder returns mutant_in=96'h5A...5A with mut_done 3 cycles after mut_start -> result_out=96'h5A...5A, done one cycle later, err=0.
REQ-039 Never assert mut_done -> done and err=1 after 255 WAIT_MUT cycles, result_out equals child_out.
REQ-040 Pulse start during BUILD and mut_done during HANDOFF -> both ignored, operation completes normally.
REQ-041 Assert rst in WAIT_MUT -> all outputs 0 next cycle, no done pulse; a new start then completes normally.
REQ-042 Run 100 back-to-back operations -> point_out is always in 0..11, and the child matches a reference model for each.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared constants and types for the genetic-algorithm pipeline blocks.
// Imported by the LFSR, the crossover controller and the mutation stage.
package ga_pkg;

    localparam int unsigned GENE_LEN   = 12;
    localparam int unsigned CHAR_WIDTH = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [CHAR_WIDTH-1:0] gene_char_t;

    function automatic logic lfsr_feedback(input logic [15:0] cur);
        return ^(cur & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/ga_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shared by the GA blocks.
// Advances every cycle; synchronous reset reloads the seed.
module ga_lfsr16
    import ga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= {state_q[14:0], lfsr_feedback(state_q)};
        end
    end

    assign state = state_q;

endmodule

// File: rtl/crossover_ctrl.sv
// Single-point crossover of two parent genes, followed by a handshake with the
// mutation stage guarded by a watchdog.
module crossover_ctrl #(
    parameter int unsigned GENE_LEN   = ga_pkg::GENE_LEN,
    parameter int unsigned CHAR_WIDTH = ga_pkg::CHAR_WIDTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [GENE_LEN*CHAR_WIDTH-1:0] parent_a,
    input  logic [GENE_LEN*CHAR_WIDTH-1:0] parent_b,
    output logic [GENE_LEN*CHAR_WIDTH-1:0] child_out,
    output logic                           mut_start,
    input  logic                           mut_done,
    input  logic [GENE_LEN*CHAR_WIDTH-1:0] mutant_in,
    output logic [GENE_LEN*CHAR_WIDTH-1:0] result_out,
    output logic [3:0]                     point_out,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    import ga_pkg::*;

    localparam int unsigned GeneW = GENE_LEN * CHAR_WIDTH;
    localparam int unsigned WdW   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StBuild   = 3'd1;
    localparam logic [2:0] StHandoff = 3'd2;
    localparam logic [2:0] StWaitMut = 3'd3;
    localparam logic [2:0] StFinish  = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [3:0]       idx_q,    idx_d;
    logic [3:0]       point_q,  point_d;
    logic [WdW-1:0]   wd_q,     wd_d;
    logic [GeneW-1:0] pa_q,     pa_d;
    logic [GeneW-1:0] pb_q,     pb_d;
    logic [GeneW-1:0] child_q,  child_d;
    logic [GeneW-1:0] result_q, result_d;
    logic             err_q,    err_d;

    logic [15:0] lfsr;
    logic [3:0]  lfsr_point;
    logic        unused_lfsr;

    ga_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:4];

    // Fold the 4-bit random value into 0..GENE_LEN-1.
    always_comb begin
        lfsr_point = lfsr[3:0];
        if (32'(lfsr[3:0]) >= GENE_LEN) begin
            lfsr_point = lfsr[3:0] - 4'(GENE_LEN);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        point_d  = point_q;
        wd_d     = wd_q;
        pa_d     = pa_q;
        pb_d     = pb_q;
        child_d  = child_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    pa_d    = parent_a;
                    pb_d    = parent_b;
                    point_d = lfsr_point;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = StBuild;
                end
            end

            StBuild: begin
                if (idx_q < point_q) begin
                    child_d[32'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH] =
                        pa_q[32'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH];
                end else begin
                    child_d[32'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH] =
                        pb_q[32'(idx_q)*CHAR_WIDTH +: CHAR_WIDTH];
                end
                if (idx_q == 4'(GENE_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = StHandoff;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            StHandoff: begin
                wd_d    = '0;
                state_d = StWaitMut;
            end

            StWaitMut: begin
                // A completion in the final watchdog cycle still counts as success.
                if (mut_done) begin
                    result_d = mutant_in;
                    state_d  = StFinish;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    result_d = child_q;
                    err_d    = 1'b1;
                    state_d  = StFinish;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            point_q  <= '0;
            wd_q     <= '0;
            pa_q     <= '0;
            pb_q     <= '0;
            child_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            point_q  <= point_d;
            wd_q     <= wd_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            child_q  <= child_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign child_out  = child_q;
    assign result_out = result_q;
    assign point_out  = point_q;
    assign err        = err_q;
    assign busy       = (state_q != StIdle);
    assign mut_start  = (state_q == StHandoff);
    assign done       = (state_q == StFinish);

endmodule

// File: tb/tb_crossover_ctrl.sv
// Scoreboard bench for crossover_ctrl: random parents and mutation-stage
// behaviour, checked against a plain arithmetic model of the crossover.
module tb_crossover_ctrl;

    localparam int GL  = 12;
    localparam int CW  = 8;
    localparam int GW  = GL * CW;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mut_done = 1'b0;
    logic [GW-1:0] parent_a = '0;
    logic [GW-1:0] parent_b = '0;
    logic [GW-1:0] mutant_in = '0;
    logic [GW-1:0] child_out, result_out;
    logic [3:0]    point_out;
    logic          mut_start, busy, done, err;

    crossover_ctrl #(
        .GENE_LEN   (GL),
        .CHAR_WIDTH (CW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .parent_a   (parent_a),
        .parent_b   (parent_b),
        .child_out  (child_out),
        .mut_start  (mut_start),
        .mut_done   (mut_done),
        .mutant_in  (mutant_in),
        .result_out (result_out),
        .point_out  (point_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1 style shift into bit 0.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct { logic [GW-1:0] child; int point; int cyc; } mut_exp_t;
    typedef struct { logic [GW-1:0] result; logic err; int cyc; } done_exp_t;
    mut_exp_t  mut_q[$];
    done_exp_t done_q[$];

    int total = 0;
    int bad   = 0;

    int            cfg_delay  = 0;  // 0 means the mutation stage never answers
    bit            cfg_glitch = 0;
    logic [GW-1:0] cfg_mutant = '0;
    logic [GW-1:0] cfg_child  = '0;

    task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] rand96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [GW-1:0] ref_child(input logic [GW-1:0] a, input logic [GW-1:0] b,
                                                 input int pt);
        logic [GW-1:0] c;
        for (int i = 0; i < GL; i++) c[i*CW +: CW] = (i < pt) ? a[i*CW +: CW] : b[i*CW +: CW];
        return c;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a pulse.
    bit   err_chk_next = 0;
    logic last_err = 0;
    always @(negedge clk) begin
        mut_exp_t  me;
        done_exp_t de;
        if (!rst) begin
            if (mut_start) begin
                chk("mut_start expected", 32'(mut_q.size() > 0), 1);
                if (mut_q.size() > 0) begin
                    me = mut_q.pop_front();
                    chk("child", child_out, me.child);
                    chk("point", point_out, me.point);
                    chk("point range", point_out < GL, 1);
                    chk("mut_start cycle", cyc, me.cyc);
                    chk("busy in handoff", busy, 1);
                end
            end
            if (done) begin
                chk("done expected", 32'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    de = done_q.pop_front();
                    chk("result", result_out, de.result);
                    chk("err at done", err, de.err);
                    chk("done cycle", cyc, de.cyc);
                    last_err = de.err;
                    err_chk_next = 1;
                end
            end else if (err_chk_next) begin
                chk("err held", err, last_err);
                err_chk_next = 0;
            end
        end
    end

    // Mutation-stage responder.
    initial begin : responder
        int h;
        int d;
        forever begin
            @(negedge clk);
            if (mut_start && !rst) begin
                h = cyc;
                d = cfg_delay;
                if (d == 0) done_q.push_back('{result: cfg_child, err: 1'b1, cyc: h + TMO + 1});
                else        done_q.push_back('{result: cfg_mutant, err: 1'b0, cyc: h + d + 1});
                if (cfg_glitch) begin
                    mut_done  = 1'b1;
                    mutant_in = rand96();
                end
                @(negedge clk);
                mut_done = 1'b0;
                if (d > 0) begin
                    repeat (d - 1) @(negedge clk);
                    mutant_in = cfg_mutant;
                    mut_done  = 1'b1;
                    @(negedge clk);
                    mut_done  = 1'b0;
                    mutant_in = rand96();
                end
            end
        end
    end

    task automatic issue(input logic [GW-1:0] a, input logic [GW-1:0] b,
                         input logic [GW-1:0] mut, input int dly, input bit glitch);
        int pt;
        int guard = 0;
        while (busy && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("idle before start", busy, 0);
        parent_a   = a;
        parent_b   = b;
        pt         = int'(m_lfsr[3:0]) % GL;
        cfg_child  = ref_child(a, b, pt);
        cfg_mutant = mut;
        cfg_delay  = dly;
        cfg_glitch = glitch;
        mut_q.push_back('{child: cfg_child, point: pt, cyc: cyc + GL + 1});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [GW-1:0] a, input logic [GW-1:0] b,
                          input logic [GW-1:0] mut, input int dly, input bit glitch,
                          input bit poke);
        int guard = 0;
        issue(a, b, mut, dly, glitch);
        if (poke) begin
            repeat (3) @(negedge clk);
            start    = 1'b1;
            parent_a = rand96();
            parent_b = rand96();
            @(negedge clk);
            start = 1'b0;
        end
        while (!done && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("done seen", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global time limit: got running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [GW-1:0] dir_child;
        logic [GW-1:0] dir_mut;
        dir_child = {{11{8'h42}}, 8'h41};
        dir_mut   = {GL{8'h5A}};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst child_out", child_out, 0);
        chk("rst result_out", result_out, 0);
        chk("rst point_out", point_out, 0);
        chk("rst mut_start", mut_start, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst busy", busy, 0);

        // First cycle after reset: seed gives point 1.
        rst = 1'b0;
        run_op({GL{8'h41}}, {GL{8'h42}}, dir_mut, 3, 0, 0);
        chk("directed point", point_out, 1);
        chk("directed child", child_out, dir_child);
        chk("directed result", result_out, dir_mut);
        chk("directed err", err, 0);

        run_op(rand96(), rand96(), rand96(), 0, 0, 0);    // watchdog expiry
        run_op(rand96(), rand96(), rand96(), TMO, 0, 0);  // answer in last watchdog cycle
        run_op(rand96(), rand96(), rand96(), 2, 1, 1);    // ignored start and mut_done

        // Reset while waiting on the mutation stage.
        issue(rand96(), rand96(), rand96(), 0, 0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        done_q.delete();
        chk("midrst child_out", child_out, 0);
        chk("midrst result_out", result_out, 0);
        chk("midrst point_out", point_out, 0);
        chk("midrst mut_start", mut_start, 0);
        chk("midrst done", done, 0);
        chk("midrst err", err, 0);
        chk("midrst busy", busy, 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        run_op(rand96(), rand96(), rand96(), 1, 0, 0);

        for (int n = 0; n < 100; n++) begin
            run_op(rand96(), rand96(), rand96(),
                   ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("mut queue drained", mut_q.size(), 0);
        chk("done queue drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
